// File: rtl/up_track_pkg.sv
// Shared types and constants for the up-counter sequence tracker.
package up_track_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_LEN = 4;
    localparam int DEF_WRAP_W   = 16;
    localparam int DEF_ERR_W    = 8;
    localparam int RUN_W        = 4;

    localparam logic [DEF_WIDTH-1:0] DEF_ONES = '1;
    localparam logic [DEF_WIDTH-1:0] DEF_ZERO = '0;

endpackage

// File: rtl/up_count_tracker_sat_counter.sv
// Saturating up counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/up_count_tracker.sv
// Locks onto a +1 count sequence and reports wraps and sequence breaks.
// Define UP_TRACK_HOLD_OK_EN to accept a repeated value (paused counter) as legal.
module up_count_tracker
    import up_track_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int WRAP_W   = DEF_WRAP_W,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              count_vld,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              stat_clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [WIDTH-1:0]  err_exp,
    output logic [WIDTH-1:0]  err_got
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIDTH-1:0]  exp_q, exp_d, got_q, got_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              wrap_pulse_q, err_pulse_q;
    logic              wrap_hit, err_hit, hold, match;
    logic [WIDTH-1:0]  expected;
    logic [RUN_W:0]    run_inc;

    assign expected = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign match    = (count_in == expected);
    assign run_inc  = {1'b0, run_q} + {{RUN_W{1'b0}}, 1'b1};

`ifdef UP_TRACK_HOLD_OK_EN
    assign hold = (count_in == prev_q);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        exp_d    = exp_q;
        got_d    = got_q;
        wrap_hit = 1'b0;
        err_hit  = 1'b0;
        if (count_vld) begin
            case (state_q)
                ST_IDLE: begin
                    prev_d  = count_in;
                    run_d   = '0;
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (!hold) begin
                        prev_d = count_in;
                        if (match) begin
                            run_d = run_inc[RUN_W-1:0];
                            if (run_inc >= LOCK_LEN[RUN_W:0]) state_d = ST_LOCKED;
                        end else begin
                            run_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!hold) begin
                        prev_d = count_in;
                        if (match) begin
                            // expected wrapped to zero exactly when prev was all-ones
                            wrap_hit = (prev_q == {WIDTH{1'b1}});
                        end else begin
                            err_hit = 1'b1;
                            exp_d   = expected;
                            got_d   = count_in;
                            run_d   = '0;
                            state_d = ST_ACQ;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        if (stat_clr)      wrap_d = '0;
        else if (wrap_hit) wrap_d = wrap_q + {{(WRAP_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            run_q        <= '0;
            exp_q        <= '0;
            got_q        <= '0;
            wrap_q       <= '0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            exp_q        <= exp_d;
            got_q        <= got_d;
            wrap_q       <= wrap_d;
            wrap_pulse_q <= wrap_hit;
            err_pulse_q  <= err_hit;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (stat_clr),
        .inc_i (err_hit),
        .cnt_o (err_count)
    );

    assign locked     = (state_q == ST_LOCKED);
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_q;
    assign err_pulse  = err_pulse_q;
    assign err_exp    = exp_q;
    assign err_got    = got_q;

endmodule
